// File: rtl/cla_pair_reducer_if.sv
// Valid/ready stream bundle carrying a data word and a group-end flag.
// Master drives data/valid/last; slave returns ready.
interface cla_pair_reducer_if #(
    parameter int W = 17
);
    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/cla_pair_reducer.sv
// Pairs consecutive CLA sums into the next adder-tree level.
// An odd trailing operand is forwarded zero-extended.
module cla_pair_reducer #(
    parameter int m  = 16,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              rst,
    cla_pair_reducer_if.slave  in_if,
    cla_pair_reducer_if.master out_if,
    output logic [CW-1:0]     res_count
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t         state_q;
    logic [m:0]     held_q;
    logic [m+1:0]   out_data_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic [CW-1:0]  cnt_q;

    logic [m:0]     in_data;
    logic [m+1:0]   sum_d;
    logic [m+1:0]   pass_d;
    logic           in_ready;
    logic           in_xfer;
    logic           out_xfer;

    assign in_data = in_if.data;

    // Only an unaccepted result stalls input; a held operand never does.
    assign in_ready = !out_valid_q || out_if.ready;
    assign in_xfer  = in_if.valid && in_ready;
    assign out_xfer = out_valid_q && out_if.ready;

    assign sum_d  = {1'b0, held_q} + {1'b0, in_data};
    assign pass_d = {1'b0, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            held_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (out_xfer) begin
                out_valid_q <= 1'b0;
                cnt_q       <= cnt_q + CNT_ONE;
            end
            // A loaded result overrides the clear above.
            if (in_xfer) begin
                unique case (state_q)
                    IDLE: begin
                        if (in_if.last) begin
                            out_data_q  <= pass_d;
                            out_last_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            held_q  <= in_data;
                            state_q <= HOLD;
                        end
                    end
                    HOLD: begin
                        out_data_q  <= sum_d;
                        out_last_q  <= in_if.last;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.data  = out_data_q;
    assign out_if.valid = out_valid_q;
    assign out_if.last  = out_last_q;
    assign res_count    = cnt_q;

endmodule

// File: tb/tb_cla_pair_reducer.sv
// Directed bench for cla_pair_reducer with m=16, CW=16.
module tb_cla_pair_reducer;

    logic        clk;
    logic        rst;
    logic [15:0] res_count;
    int          checks;
    int          failures;
    int          exp_cnt;

    cla_pair_reducer_if #(.W(17)) in_if ();
    cla_pair_reducer_if #(.W(18)) out_if ();

    cla_pair_reducer #(.m(16), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (in_if),
        .out_if    (out_if),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand and wait (bounded) for it to be taken.
    // Returns 1 ns after the accepting edge.
    task automatic send(input logic [16:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_if.data  = d;
        in_if.last  = l;
        in_if.valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_if.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout data=%h in_ready=%b want 1", d, in_if.ready);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        in_if.data  = '0;
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
        out_if.ready = 1'b1;
        rst = 1'b1;
        #12;
        checks++;
        if (out_if.valid !== 1'b0 || out_if.data !== 18'h0 || out_if.last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got v=%b d=%h l=%b want 0 0 0",
                     out_if.valid, out_if.data, out_if.last);
        end
        checks++;
        if (res_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt got %0d want 0", res_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset_mid();
        out_if.ready = 1'b1;
        send(17'h0EEAD, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_if.valid !== 1'b0 || res_count !== 16'd0) begin
            failures++;
            $display("FAIL midrst got v=%b cnt=%0d want 0 0", out_if.valid, res_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 0;
        send(17'h00005, 1'b1);
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== 18'h00005 || out_if.last !== 1'b1) begin
            failures++;
            $display("FAIL midrst_out got v=%b d=%h l=%b want 1 00005 1",
                     out_if.valid, out_if.data, out_if.last);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    task automatic test_pair();
        apply_reset();
        out_if.ready = 1'b1;
        send(17'h1191B, 1'b0);
        checks++;
        if (out_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL pair_early got v=%b want 0", out_if.valid);
        end
        send(17'h1D5DA, 1'b1);
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== 18'h2EEF5 || out_if.last !== 1'b1) begin
            failures++;
            $display("FAIL pair_out got v=%b d=%h l=%b want 1 2eef5 1",
                     out_if.valid, out_if.data, out_if.last);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (res_count !== 16'(exp_cnt) || out_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL pair_cnt got cnt=%0d v=%b want %0d 0",
                     res_count, out_if.valid, exp_cnt);
        end
    endtask

    task automatic test_max();
        send(17'h1FFFF, 1'b0);
        send(17'h1FFFF, 1'b1);
        checks++;
        if (out_if.data !== 18'h3FFFE || out_if.last !== 1'b1) begin
            failures++;
            $display("FAIL max_out got d=%h l=%b want 3fffe 1", out_if.data, out_if.last);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    task automatic test_odd();
        send(17'h00003, 1'b0);
        send(17'h00004, 1'b0);
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== 18'h00007 || out_if.last !== 1'b0) begin
            failures++;
            $display("FAIL odd_pair got v=%b d=%h l=%b want 1 00007 0",
                     out_if.valid, out_if.data, out_if.last);
        end
        send(17'h00009, 1'b1);
        exp_cnt++;
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== 18'h00009 || out_if.last !== 1'b1) begin
            failures++;
            $display("FAIL odd_tail got v=%b d=%h l=%b want 1 00009 1",
                     out_if.valid, out_if.data, out_if.last);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (res_count !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL odd_cnt got %0d want %0d", res_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_if.ready = 1'b0;
        send(17'h1191B, 1'b0);
        send(17'h1D5DA, 1'b1);
        // Offer a stray operand that must be refused during the stall.
        in_if.data  = 17'h00001;
        in_if.last  = 1'b0;
        in_if.valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_if.ready !== 1'b0 || out_if.valid !== 1'b1 ||
                out_if.data !== 18'h2EEF5 || out_if.last !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d got rdy=%b v=%b d=%h l=%b want 0 1 2eef5 1",
                         i, in_if.ready, out_if.valid, out_if.data, out_if.last);
            end
        end
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        #1;
        checks++;
        if (in_if.ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got rdy=%b want 1", in_if.ready);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (out_if.valid !== 1'b0 || res_count !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL bp_drain got v=%b cnt=%0d want 0 %0d",
                     out_if.valid, res_count, exp_cnt);
        end
        send(17'h00002, 1'b1);
        checks++;
        if (out_if.data !== 18'h00002 || out_if.last !== 1'b1) begin
            failures++;
            $display("FAIL bp_idle got d=%h l=%b want 00002 1", out_if.data, out_if.last);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [16:0] ops [8];
        logic [17:0] exp_d [4];
        logic        exp_l [4];
        logic [17:0] got_d [$];
        logic        got_l [$];
        ops = '{17'd1, 17'd2, 17'd3, 17'd4, 17'd10, 17'd20, 17'd100, 17'd200};
        exp_d = '{18'd3, 18'd7, 18'd30, 18'd300};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        out_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_if.data  = ops[i];
            in_if.last  = (i == 7);
            in_if.valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_if.ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready op=%0d got %b want 1", i, in_if.ready);
            end
            if (out_if.valid === 1'b1) begin
                got_d.push_back(out_if.data);
                got_l.push_back(out_if.last);
            end
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_if.valid === 1'b1) begin
                got_d.push_back(out_if.data);
                got_l.push_back(out_if.last);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (got_d.size() != 4) begin
            failures++;
            $display("FAIL b2b_count got %0d results want 4", got_d.size());
        end
        for (int k = 0; k < 4 && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
                failures++;
                $display("FAIL b2b_res k=%0d got d=%h l=%b want %h %b",
                         k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
        checks++;
        if (res_count !== 16'd4) begin
            failures++;
            $display("FAIL b2b_cnt got %0d want 4", res_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        test_reset();
        test_reset_mid();
        test_pair();
        test_max();
        test_odd();
        test_backpressure();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_pair_reducer.md
Name: cla_pair_reducer

Overview:
- Downstream consumer of the CLA stage in the multi-operand binary tree adder.
- Takes the stream of (m+1)-bit CLA sums and adds consecutive pairs to form the next tree level, producing (m+2)-bit results.
- An odd trailing operand, marked by in_last, is passed through zero-extended.
- Valid/ready handshake on both sides; one registered output stage with backpressure.

Parameters:
- m, 16, operand width of the upstream CLA inputs; the CLA sum is m+1 bits and this block's output is m+2 bits.
- CW, 16, width of the emitted-result counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  m+1  CLA sum word ({carry, sum} as produced upstream).
- in_valid  input  1  in_data and in_last are valid.
- in_last  input  1  final operand of the current group.
- in_ready  output  1  block can accept this cycle.
- out_data  output  m+2  pair sum, or zero-extended single operand.
- out_valid  output  1  out_data and out_last are valid.
- out_last  output  1  result closes the group.
- out_ready  input  1  downstream accepts out_data.
- res_count  output  CW  number of results accepted downstream since reset.

Behaviour:
- Reset (async, rst=1): state=IDLE, held operand=0, out_data=0, out_valid=0, out_last=0, res_count=0. Reset mid-operation discards any held operand and any pending output.
- in_ready = !out_valid || out_ready. This is combinational and independent of state.
- Input transfer = in_valid && in_ready.
- Output transfer = out_valid && out_ready.
- FSM states:
  - IDLE: no operand held.
  - HOLD: one operand held.
- IDLE + transfer + !in_last: store in_data; go to HOLD; no output.
- IDLE + transfer + in_last: out_data = {1'b0, in_data}; out_last=1; out_valid=1 next cycle; stay in IDLE.
- HOLD + transfer: out_data = held + in_data, full m+2 width, never overflows. out_last = in_last; out_valid=1 next cycle; go to IDLE.
- Latency: the result is visible the cycle after the completing input transfer.
- Output register:
  - It loads only on a result-producing transfer.
  - Otherwise, out_valid clears after an output transfer.
  - If an output transfer and a new result load occur in the same cycle, the new result wins and out_valid stays 1. This gives full throughput of one result per two input cycles.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Holding an operand does not by itself block input. Only a pending, unaccepted output deasserts in_ready.
- in_valid with in_ready=0: no state change; upstream must hold its data.
- res_count increments on each output transfer and wraps modulo 2^CW.
- A new group starts in IDLE after any in_last transfer. in_last in HOLD closes the pair and the group.

Test Plan:
1. Reset mid-stream: send in_data=17'h0EEAD (no last), assert rst one cycle -> IDLE, out_valid=0, res_count=0. Then send 17'h00005 + last -> out_data=18'h00005, out_last=1.
2. Basic pair (m=16): in_data=17'h1191B, then 17'h1D5DA + last, out_ready=1 -> one cycle later out_data=18'h2EEF5, out_valid=1, out_last=1; res_count=1.
3. Max values: 17'h1FFFF, 17'h1FFFF -> out_data=18'h3FFFE, no truncation.
4. Odd group: values 3, 4, 9 with last on 9 -> outputs 18'h00007 (out_last=0), then 18'h00009 (out_last=1).
5. Backpressure: out_ready=0 while the result 18'h2EEF5 is pending -> in_ready=0 and out_data stable for 5 cycles. Then out_ready=1 -> one output transfer, in_ready=1.
6. Streaming: 8 back-to-back operands with out_ready=1 -> 4 results, in_ready never drops, res_count=4.
